// File: rtl/mem_arbiter_if.sv
// Bus bundle between the core's fetch/memory stages, the arbiter and the unified memory.
// The arbiter takes the slave view; the core/memory side (or a bench) takes the master view.
interface mem_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          i_req;
    logic [AW-1:0] i_addr;
    logic [DW-1:0] i_rdata;
    logic          i_valid;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic [DW-1:0] d_rdata;
    logic          d_valid;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          stall_f;
    logic          stall_m;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        output i_rdata, i_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
        input  i_rdata, i_valid, d_rdata, d_valid,
               mem_en, mem_we, mem_addr, mem_wdata, stall_f, stall_m
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the fetch and data ports,
// with a fixed-wait-state access sequencer and registered, one-cycle-valid read returns.
module mem_arbiter #(
    parameter int LATENCY = 2,
    parameter int AW      = 32,
    parameter int DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          last_d, last_d_nxt;
    logic          side_d, side_d_nxt;
    logic          we_l, we_l_nxt;
    logic          grant_d;
    logic          mem_en_r, mem_en_nxt;
    logic          mem_we_r, mem_we_nxt;
    logic [AW-1:0] mem_addr_r, mem_addr_nxt;
    logic [DW-1:0] mem_wdata_r, mem_wdata_nxt;
    logic [DW-1:0] i_rdata_r, i_rdata_nxt;
    logic [DW-1:0] d_rdata_r, d_rdata_nxt;
    logic          i_valid_r, i_valid_nxt;
    logic          d_valid_r, d_valid_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cnt         <= '0;
            last_d      <= 1'b0;
            side_d      <= 1'b0;
            we_l        <= 1'b0;
            mem_en_r    <= 1'b0;
            mem_we_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            i_rdata_r   <= '0;
            d_rdata_r   <= '0;
            i_valid_r   <= 1'b0;
            d_valid_r   <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            last_d      <= last_d_nxt;
            side_d      <= side_d_nxt;
            we_l        <= we_l_nxt;
            mem_en_r    <= mem_en_nxt;
            mem_we_r    <= mem_we_nxt;
            mem_addr_r  <= mem_addr_nxt;
            mem_wdata_r <= mem_wdata_nxt;
            i_rdata_r   <= i_rdata_nxt;
            d_rdata_r   <= d_rdata_nxt;
            i_valid_r   <= i_valid_nxt;
            d_valid_r   <= d_valid_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt;
        last_d_nxt    = last_d;
        side_d_nxt    = side_d;
        we_l_nxt      = we_l;
        grant_d       = 1'b0;
        mem_en_nxt    = 1'b0;
        mem_we_nxt    = 1'b0;
        mem_addr_nxt  = mem_addr_r;
        mem_wdata_nxt = mem_wdata_r;
        i_rdata_nxt   = i_rdata_r;
        d_rdata_nxt   = d_rdata_r;
        i_valid_nxt   = 1'b0;
        d_valid_nxt   = 1'b0;

        case (state)
            IDLE: begin
                if (bus.i_req || bus.d_req) begin
                    // On a tie the data port wins unless it had the previous grant.
                    grant_d       = bus.d_req && (!bus.i_req || !last_d);
                    side_d_nxt    = grant_d;
                    last_d_nxt    = grant_d;
                    we_l_nxt      = grant_d && bus.d_we;
                    mem_addr_nxt  = grant_d ? bus.d_addr : bus.i_addr;
                    mem_wdata_nxt = grant_d ? bus.d_wdata : '0;
                    cnt_nxt       = (grant_d && bus.d_we) ? '0 : CW'(LATENCY - 1);
                    mem_en_nxt    = 1'b1;
                    mem_we_nxt    = grant_d && bus.d_we;
                    state_nxt     = XFER;
                end
            end
            XFER: begin
                if (cnt == '0) begin
                    if (!we_l) begin
                        if (side_d) d_rdata_nxt = bus.mem_rdata;
                        else        i_rdata_nxt = bus.mem_rdata;
                    end
                    d_valid_nxt = side_d;
                    i_valid_nxt = !side_d;
                    state_nxt   = DONE;
                end else begin
                    cnt_nxt    = cnt - 1'b1;
                    mem_en_nxt = 1'b1;
                end
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.mem_en    = mem_en_r;
    assign bus.mem_we    = mem_we_r;
    assign bus.mem_addr  = mem_addr_r;
    assign bus.mem_wdata = mem_wdata_r;
    assign bus.i_rdata   = i_rdata_r;
    assign bus.d_rdata   = d_rdata_r;
    assign bus.i_valid   = i_valid_r;
    assign bus.d_valid   = d_valid_r;
    assign bus.stall_f   = bus.i_req & ~i_valid_r;
    assign bus.stall_m   = bus.d_req & ~d_valid_r;
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: cycle vectors for single/tie/store accesses, plus
// hand sequences for sustained contention, mid-access reset and a LATENCY=1 build.
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_arbiter_if #(.AW(32), .DW(32)) a ();
    mem_arbiter_if #(.AW(32), .DW(32)) b ();

    mem_arbiter #(.LATENCY(2), .AW(32), .DW(32)) dut  (.clk(clk), .reset(reset), .bus(a));
    mem_arbiter #(.LATENCY(1), .AW(32), .DW(32)) dut1 (.clk(clk), .reset(reset), .bus(b));

    logic [31:0] mem_a [0:255];
    logic [31:0] mem_b [0:255];
    assign a.mem_rdata = mem_a[a.mem_addr[9:2]];
    assign b.mem_rdata = mem_b[b.mem_addr[9:2]];
    always @(posedge clk) if (a.mem_en && a.mem_we) mem_a[a.mem_addr[9:2]] <= a.mem_wdata;
    always @(posedge clk) if (b.mem_en && b.mem_we) mem_b[b.mem_addr[9:2]] <= b.mem_wdata;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        ir;
        logic [31:0] ia;
        logic        dr;
        logic        dw;
        logic [31:0] da;
        logic [31:0] dd;
        logic        iv, dv, en, we, sf, sm;
        logic [31:0] ird, drd, maddr, mwd;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr,
                                input logic dw, input logic [31:0] da, input logic [31:0] dd,
                                input logic iv, input logic dv, input logic en, input logic we,
                                input logic sf, input logic sm, input logic [31:0] ird,
                                input logic [31:0] drd, input logic [31:0] maddr,
                                input logic [31:0] mwd);
        vec_t r;
        r.ir = ir; r.ia = ia; r.dr = dr; r.dw = dw; r.da = da; r.dd = dd;
        r.iv = iv; r.dv = dv; r.en = en; r.we = we; r.sf = sf; r.sm = sm;
        r.ird = ird; r.drd = drd; r.maddr = maddr; r.mwd = mwd;
        return r;
    endfunction

    task automatic drive_a(input logic ir, input logic [31:0] ia, input logic dr,
                           input logic dw, input logic [31:0] da, input logic [31:0] dd);
        a.i_req = ir; a.i_addr = ia; a.d_req = dr; a.d_we = dw; a.d_addr = da; a.d_wdata = dd;
    endtask

    task automatic drive_b(input logic ir, input logic [31:0] ia, input logic dr,
                           input logic dw, input logic [31:0] da, input logic [31:0] dd);
        b.i_req = ir; b.i_addr = ia; b.d_req = dr; b.d_we = dw; b.d_addr = da; b.d_wdata = dd;
    endtask

    task automatic chk_zero_a(input string tag);
        chk({tag, " mem_en"},    {31'd0, a.mem_en},  32'd0);
        chk({tag, " mem_we"},    {31'd0, a.mem_we},  32'd0);
        chk({tag, " mem_addr"},  a.mem_addr,         32'd0);
        chk({tag, " mem_wdata"}, a.mem_wdata,        32'd0);
        chk({tag, " i_rdata"},   a.i_rdata,          32'd0);
        chk({tag, " d_rdata"},   a.d_rdata,          32'd0);
        chk({tag, " i_valid"},   {31'd0, a.i_valid}, 32'd0);
        chk({tag, " d_valid"},   {31'd0, a.d_valid}, 32'd0);
    endtask

    localparam logic [31:0] INS0 = 32'hE59F1004;
    localparam logic [31:0] INS1 = 32'hE3A00001;
    localparam logic [31:0] LD   = 32'h0000002A;
    localparam logic [31:0] BEEF = 32'hDEADBEEF;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test end");
        $fatal(1, "watchdog");
    end

    initial begin
        logic exp_i;
        int   pulses;
        string nm;

        for (int k = 0; k < 256; k++) begin
            mem_a[k] = 32'd0;
            mem_b[k] = 32'd0;
        end
        mem_a[0]  = INS1;
        mem_a[2]  = INS0;
        mem_a[64] = LD;
        mem_b[2]  = 32'h12345678;

        reset = 1'b0;
        drive_a(0, 0, 0, 0, 0, 0);
        drive_b(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero_a("reset");
        chk("reset b mem_en", {31'd0, b.mem_en}, 32'd0);
        chk("reset stall_f", {31'd0, a.stall_f}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Single fetch
        vt.push_back(mk(1, 8, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0,  0, 0, 0, 0));
        vt.push_back(mk(1, 8, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0,  0, 0, 8, 0));
        vt.push_back(mk(1, 8, 0, 0, 0, 0,  0, 0, 1, 0, 1, 0,  0, 0, 8, 0));
        vt.push_back(mk(1, 8, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0,  INS0, 0, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0,  INS0, 0, 0, 0));
        // Tie: data load first, then fetch
        vt.push_back(mk(1, 0, 1, 0, 32'h100, 0,  0, 0, 0, 0, 1, 1,  INS0, 0, 0, 0));
        vt.push_back(mk(1, 0, 1, 0, 32'h100, 0,  0, 0, 1, 0, 1, 1,  INS0, 0, 32'h100, 0));
        vt.push_back(mk(1, 0, 1, 0, 32'h100, 0,  0, 0, 1, 0, 1, 1,  INS0, 0, 32'h100, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0,        0, 1, 0, 0, 1, 0,  INS0, LD, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0,        0, 0, 0, 0, 1, 0,  INS0, LD, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0,        0, 0, 1, 0, 1, 0,  INS0, LD, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0,        0, 0, 1, 0, 1, 0,  INS0, LD, 0, 0));
        vt.push_back(mk(1, 0, 0, 0, 0, 0,        1, 0, 0, 0, 0, 0,  INS1, LD, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0,        0, 0, 0, 0, 0, 0,  INS1, LD, 0, 0));
        // Store
        vt.push_back(mk(0, 0, 1, 1, 32'h64, BEEF,  0, 0, 0, 0, 0, 1,  INS1, LD, 0, 0));
        vt.push_back(mk(0, 0, 1, 1, 32'h64, BEEF,  0, 0, 1, 1, 0, 1,  INS1, LD, 32'h64, BEEF));
        vt.push_back(mk(0, 0, 1, 1, 32'h64, BEEF,  0, 1, 0, 0, 0, 0,  INS1, LD, 0, 0));
        vt.push_back(mk(0, 0, 0, 0, 0, 0,          0, 0, 0, 0, 0, 0,  INS1, LD, 0, 0));

        for (int k = 0; k < vt.size(); k++) begin
            @(posedge clk); #1;
            drive_a(vt[k].ir, vt[k].ia, vt[k].dr, vt[k].dw, vt[k].da, vt[k].dd);
            @(negedge clk);
            nm = $sformatf("vec%0d", k);
            chk({nm, " i_valid"}, {31'd0, a.i_valid}, {31'd0, vt[k].iv});
            chk({nm, " d_valid"}, {31'd0, a.d_valid}, {31'd0, vt[k].dv});
            chk({nm, " mem_en"},  {31'd0, a.mem_en},  {31'd0, vt[k].en});
            chk({nm, " mem_we"},  {31'd0, a.mem_we},  {31'd0, vt[k].we});
            chk({nm, " stall_f"}, {31'd0, a.stall_f}, {31'd0, vt[k].sf});
            chk({nm, " stall_m"}, {31'd0, a.stall_m}, {31'd0, vt[k].sm});
            chk({nm, " i_rdata"}, a.i_rdata, vt[k].ird);
            chk({nm, " d_rdata"}, a.d_rdata, vt[k].drd);
            if (vt[k].en) chk({nm, " mem_addr"}, a.mem_addr, vt[k].maddr);
            if (vt[k].we) chk({nm, " mem_wdata"}, a.mem_wdata, vt[k].mwd);
        end
        chk("store landed", mem_a[25], BEEF);

        // Sustained contention: previous grant was D, so grants run I,D,I,D...
        exp_i  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 46; c++) begin
            @(posedge clk); #1;
            if (c < 40) drive_a(1, 8, 1, 0, 32'h64, 0);
            else        drive_a(0, 0, 0, 0, 0, 0);
            @(negedge clk);
            if (a.i_valid && a.d_valid) chk("rr both valid", 32'd1, 32'd0);
            if (a.i_valid || a.d_valid) begin
                pulses++;
                chk("rr side", {31'd0, a.i_valid}, {31'd0, exp_i});
                if (a.i_valid) chk("rr i_rdata", a.i_rdata, INS0);
                else           chk("rr d_rdata", a.d_rdata, BEEF);
                exp_i = ~exp_i;
            end
        end
        chk("rr pulses", pulses, 32'd10);

        // Reset during second XFER cycle of a load
        @(posedge clk); #1;
        drive_a(0, 0, 1, 0, 32'h100, 0);
        @(posedge clk);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk_zero_a("midreset");
        chk("midreset stall_m", {31'd0, a.stall_m}, 32'd1);
        drive_a(0, 0, 0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("post-reset d_valid", {31'd0, a.d_valid}, 32'd0);
            chk("post-reset mem_en", {31'd0, a.mem_en}, 32'd0);
        end
        // Re-issued load tied with a fetch: reset restored last_grant=I, so D goes first
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            drive_a(c < 8, 8, c < 3, 0, 32'h100, 0);
            @(negedge clk);
            chk("reissue d_valid", {31'd0, a.d_valid}, {31'd0, c == 3});
            chk("reissue i_valid", {31'd0, a.i_valid}, {31'd0, c == 7});
            chk("reissue mem_en", {31'd0, a.mem_en}, {31'd0, c == 1 || c == 2 || c == 5 || c == 6});
        end
        chk("reissue d_rdata", a.d_rdata, LD);
        chk("reissue i_rdata", a.i_rdata, INS0);

        // LATENCY=1 instance: read, store, load back
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            drive_b(c < 2, 8, 0, 0, 0, 0);
            @(negedge clk);
            chk("l1 rd mem_en", {31'd0, b.mem_en}, {31'd0, c == 1});
            chk("l1 rd i_valid", {31'd0, b.i_valid}, {31'd0, c == 2});
        end
        chk("l1 i_rdata", b.i_rdata, 32'h12345678);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            drive_b(0, 0, c < 2, 1, 32'h10, 32'hCAFEF00D);
            @(negedge clk);
            chk("l1 wr mem_en", {31'd0, b.mem_en}, {31'd0, c == 1});
            chk("l1 wr mem_we", {31'd0, b.mem_we}, {31'd0, c == 1});
            chk("l1 wr d_valid", {31'd0, b.d_valid}, {31'd0, c == 2});
        end
        chk("l1 store landed", mem_b[4], 32'hCAFEF00D);
        chk("l1 store keeps d_rdata", b.d_rdata, 32'd0);
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            drive_b(0, 0, c < 2, 0, 32'h10, 0);
            @(negedge clk);
            chk("l1 ld d_valid", {31'd0, b.d_valid}, {31'd0, c == 2});
        end
        chk("l1 d_rdata", b.d_rdata, 32'hCAFEF00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
